// File: rtl/booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter
//
// Sequencer and two-port round-robin arbiter in front of a shared Radix-4 Booth
// multiplier. It grants one requester, loads the operands into the multiplier,
// runs it for exactly ITER iteration cycles, waits CAP_LAT cycles, and then
// holds the 2N-bit product in a response register until it is consumed.
// The multiplier has no stop condition of its own, so the iteration counter
// here is the only thing that bounds a run.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req{0,1}_valid/_ready         request handshakes (ready is combinational)
//   req{0,1}_a/_b [N]             signed operands
//   mul_start                     1 = multiplier held in load/clear/freeze
//   mul_start_i, mul_start_shift  multiplier configuration constants
//   mul_a, mul_b [N]              operands driven to the multiplier
//   mul_product [2N]              multiplier result
//   resp_valid/_ready             response handshake
//   resp_id                       requester that owns the response
//   resp_product [2N]             captured signed product
//   busy                          high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module booth_mul_arbiter #(
  parameter int N       = 32,
  parameter int ITER    = N / 2,
  parameter int CAP_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           mul_start,
  output logic [4:0]     mul_start_i,
  output logic [4:0]     mul_start_shift,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_product,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [2*N-1:0] resp_product,
  output logic           busy
);

  // One counter serves both the RUN and the CAPTURE phase.
  localparam int CNT_MAX = (ITER > CAP_LAT) ? ITER : CAP_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic             r_mul_start;
  logic             r_busy;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [N-1:0]     r_mul_a;
  logic [N-1:0]     r_mul_b;
  logic [2*N-1:0]   r_resp_product;

  logic w_grant_id;
  logic w_accept;

  // With both requesters valid the pointer decides; otherwise the single valid
  // requester wins (req1_valid alone selects 1, req0_valid alone selects 0).
  assign w_grant_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;

  // Gated by rst_n so nothing is accepted while reset is asserted.
  assign w_accept   = rst_n & (r_state == S_IDLE) & (req0_valid | req1_valid);

  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept &  w_grant_id;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values; blocking here would chain updates within
  // one edge and diverge from the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_ptr          <= 1'b0;
      r_mul_start    <= 1'b1;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_resp_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mul_a   <= w_grant_id ? req1_a : req0_a;
            r_mul_b   <= w_grant_id ? req1_b : req0_b;
            r_resp_id <= w_grant_id;
            r_ptr     <= ~w_grant_id;
            r_busy    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // mul_start stays high for this cycle so the multiplier loads a/b.
          r_cnt       <= '0;
          r_mul_start <= 1'b0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          // Leave after exactly ITER cycles; one more iteration would corrupt
          // the product, so the counter never wraps back into RUN.
          if (r_cnt == CNT_W'(ITER - 1)) begin
            r_cnt       <= '0;
            r_mul_start <= 1'b1;
            r_state     <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (r_cnt == CNT_W'(CAP_LAT - 1)) begin
            r_resp_product <= mul_product;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_mul_start  <= 1'b1;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_start       = r_mul_start;
  assign mul_start_i     = 5'd1;
  assign mul_start_shift = 5'd0;
  assign mul_a           = r_mul_a;
  assign mul_b           = r_mul_b;
  assign resp_valid      = r_resp_valid;
  assign resp_id         = r_resp_id;
  assign resp_product    = r_resp_product;
  assign busy            = r_busy;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_arbiter
//
// Bench for booth_mul_arbiter. A cycle-accurate Booth multiplier stand-in
// returns the correct product only after exactly ITER iterations, so a run of
// the wrong length or a mistimed sample yields a wrong product. A transaction
// model (time since acceptance, pointer, latched operands) predicts every
// output each cycle; directed cases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_booth_mul_arbiter;

  localparam int N       = 32;
  localparam int ITER    = 16;
  localparam int CAP_LAT = 1;
  localparam int P       = 2 * N;
  localparam int RESP_AT = ITER + CAP_LAT + 1;  // cycles from accept to resp_valid

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  typedef struct {
    logic         id;
    logic [P-1:0] prod;
    int           lat;
    int           acc;
    int           hs;
  } rsp_t;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         mul_start;
  logic [4:0]   mul_start_i, mul_start_shift;
  logic [N-1:0] mul_a, mul_b;
  logic [P-1:0] mul_product;
  logic         resp_valid, resp_ready, resp_id;
  logic [P-1:0] resp_product;
  logic         busy;

  booth_mul_arbiter #(.N(N), .ITER(ITER), .CAP_LAT(CAP_LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_a          (req0_a),
    .req0_b          (req0_b),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_a          (req1_a),
    .req1_b          (req1_b),
    .mul_start       (mul_start),
    .mul_start_i     (mul_start_i),
    .mul_start_shift (mul_start_shift),
    .mul_a           (mul_a),
    .mul_b           (mul_b),
    .mul_product     (mul_product),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_product    (resp_product),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within budget, expected one at %0t", name, $time);
  endtask

  function automatic logic [P-1:0] mul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [P-1:0] sa;
    logic signed [P-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Multiplier stand-in: start=1 loads operands and freezes the product;
  // each start=0 cycle is one iteration, correct only at exactly ITER.
  logic [N-1:0] mm_a = '0, mm_b = '0;
  logic [P-1:0] mm_prod = '0;
  int           mm_k = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      mm_k <= 0;
      mm_a <= mul_a;
      mm_b <= mul_b;
    end else begin
      mm_k    <= mm_k + 1;
      mm_prod <= (mm_k + 1 == ITER) ? mul_ref(mm_a, mm_b)
                                    : mul_ref(mm_a, mm_b) ^ {32'hDEADBEEF, 32'(mm_k) | 32'h1};
    end
  end
  assign mul_product = mm_prod;

  // Transaction model: m_t = -1 when idle, else edges since acceptance.
  int           m_t = -1;
  logic         m_ptr = 1'b0, m_id = 1'b0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [P-1:0] m_prod = '0;

  logic e_idle, e_gnt0, e_gnt1, e_rv, e_start;
  always_comb begin
    e_idle = (m_t < 0);
    e_gnt0 = 1'b0;
    e_gnt1 = 1'b0;
    if (rst_n && e_idle) begin
      if (req0_valid && req1_valid) begin
        if (m_ptr) e_gnt1 = 1'b1;
        else       e_gnt0 = 1'b1;
      end else begin
        e_gnt0 = req0_valid;
        e_gnt1 = req1_valid;
      end
    end
    e_rv    = !e_idle && (m_t >= RESP_AT);
    e_start = e_idle || (m_t == 0) || (m_t > ITER);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t    <= -1;
      m_ptr  <= 1'b0;
      m_id   <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
      m_prod <= '0;
    end else if (m_t < 0) begin
      if (e_gnt0 || e_gnt1) begin
        m_t   <= 0;
        m_id  <= e_gnt1;
        m_ptr <= !e_gnt1;
        m_a   <= e_gnt1 ? req1_a : req0_a;
        m_b   <= e_gnt1 ? req1_b : req0_b;
      end
    end else if (m_t >= RESP_AT) begin
      if (resp_ready) m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == RESP_AT) m_prod <= mul_ref(m_a, m_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req0_ready", req0_ready, e_gnt0);
      check("req1_ready", req1_ready, e_gnt1);
      check("busy", busy, !e_idle);
      check("mul_start", mul_start, e_start);
      check("resp_valid", resp_valid, e_rv);
      check("mul_a", mul_a, m_a);
      check("mul_b", mul_b, m_b);
      check("resp_id", resp_id, m_id);
      check("resp_product", resp_product, m_prod);
      check("mul_start_i", mul_start_i, 5'd1);
      check("mul_start_shift", mul_start_shift, 5'd0);
    end
  end

  // Driver and response monitor: operands come from per-port queues,
  // valid is held while a queue is non-empty, popped on handshake.
  op_t  q0[$], q1[$];
  rsp_t rsp_log[$];
  int   cyc = 0, acc_cyc = 0, rise_cyc = 0;
  logic prev_rv = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (req0_valid && req0_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        acc_cyc = cyc;
      end
      if (req1_valid && req1_ready && q1.size() > 0) begin
        void'(q1.pop_front());
        acc_cyc = cyc;
      end
      if (resp_valid && !prev_rv) rise_cyc = cyc - 1;
      if (resp_valid && resp_ready)
        rsp_log.push_back('{id: resp_id, prod: resp_product, lat: rise_cyc - acc_cyc,
                            acc: acc_cyc, hs: cyc});
      prev_rv = resp_valid;
      #2;
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (q0.size() > 0) {req0_a, req0_b} = q0[0];
      if (q1.size() > 0) {req1_a, req1_b} = q1[0];
    end
  end

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rsp_log.size() < n) fail_timeout(name);
  endtask

  task automatic expect_rsp(input string name, input logic id, input logic [P-1:0] prod,
                            input int lat);
    rsp_t r;
    wait_rsp(1, 200, name);
    if (rsp_log.size() > 0) begin
      r = rsp_log.pop_front();
      check({name, ".id"}, r.id, id);
      check({name, ".product"}, r.prod, prod);
      if (lat >= 0) check({name, ".latency"}, r.lat, lat);
    end
  endtask

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected end of test at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsp_t r1, r2;
    int   k;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b1;

    // Contention from reset: both requests present while reset is asserted.
    q0.push_back('{a: 32'd2, b: 32'd4});
    q1.push_back('{a: 32'd5, b: 32'd7});
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst.req0_ready", req0_ready, 1'b0);
    check("rst.req1_ready", req1_ready, 1'b0);
    check("rst.mul_start", mul_start, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.resp_product", resp_product, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_rsp("cont0", 1'b0, 64'd8, RESP_AT);
    expect_rsp("cont1", 1'b1, 64'd35, RESP_AT);

    // Four back-to-back pairs with both requesters always valid.
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{a: $urandom(), b: $urandom()});
      q1.push_back('{a: $urandom(), b: $urandom()});
    end
    wait_rsp(8, 400, "pairs");
    for (int i = 0; i < 8; i++) begin
      if (rsp_log.size() > 0) begin
        r1 = rsp_log.pop_front();
        check($sformatf("pairs.id%0d", i), r1.id, (i % 2 == 1));
      end
    end

    // Single operation and signed operation.
    q0.push_back('{a: 32'd3, b: 32'd5});
    expect_rsp("single", 1'b0, 64'h0000_0000_0000_000F, RESP_AT);
    q1.push_back('{a: 32'hFFFF_FFF9, b: 32'd6});
    expect_rsp("signed", 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, RESP_AT);

    // Backpressure: response held for 5 cycles while req0 waits.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    q1.push_back('{a: 32'd11, b: 32'd13});
    k = 0;
    while (!resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid) fail_timeout("bp.resp_valid");
    q0.push_back('{a: 32'd17, b: 32'd19});
    repeat (5) @(negedge clk);
    check("bp.req0_ready", req0_ready, 1'b0);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_rsp(2, 200, "bp");
    if (rsp_log.size() >= 2) begin
      r1 = rsp_log.pop_front();
      r2 = rsp_log.pop_front();
      check("bp.id", r1.id, 1'b1);
      check("bp.product", r1.prod, 64'd143);
      check("bp.next_id", r2.id, 1'b0);
      check("bp.next_product", r2.prod, 64'd323);
      check("bp.accept_gap", r2.acc, r1.hs + 1);
    end

    // Reset in the middle of RUN (iteration 7).
    q0.push_back('{a: 32'h1234_5678, b: 32'h9ABC_DEF0});
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!busy) fail_timeout("midrun.busy");
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrun.busy", busy, 1'b0);
    check("midrun.resp_valid", resp_valid, 1'b0);
    check("midrun.mul_start", mul_start, 1'b1);
    check("midrun.mul_a", mul_a, '0);
    check("midrun.resp_product", resp_product, '0);
    q0.push_back('{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF});
    wait_rsp(1, 200, "after_reset");
    check("after_reset.count", rsp_log.size(), 1);
    expect_rsp("after_reset", 1'b0, 64'h0000_0000_0000_0001, RESP_AT);

    // Extremes.
    q0.push_back('{a: 32'h8000_0000, b: 32'h8000_0000});
    expect_rsp("ext_minmin", 1'b0, 64'h4000_0000_0000_0000, RESP_AT);
    q1.push_back('{a: 32'h7FFF_FFFF, b: 32'h8000_0000});
    expect_rsp("ext_maxmin", 1'b1, 64'hC000_0000_8000_0000, RESP_AT);

    // Randomized traffic with random backpressure; the model checks each cycle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0 && q0.size() < 2)
        q0.push_back('{a: rand_operand(), b: rand_operand()});
      if ($urandom_range(0, 9) == 0 && q1.size() < 2)
        q1.push_back('{a: rand_operand(), b: rand_operand()});
    end
    resp_ready = 1'b1;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (q0.size() > 0 || q1.size() > 0 || busy) fail_timeout("drain");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
